// File: rtl/lmac_reg_reader_if.sv
// lmac_reg_reader_if: AXI4-Lite read-channel bundle between host bridge and lmac_reg_reader
interface lmac_reg_reader_if;
  logic [17:0] s_axil_araddr;
  logic        s_axil_arvalid;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready;
  modport master (
    output s_axil_araddr, s_axil_arvalid, s_axil_rready,
    input  s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid
  );
  modport slave (
    input  s_axil_araddr, s_axil_arvalid, s_axil_rready,
    output s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid
  );
endinterface

// File: rtl/lmac_reg_reader.sv
// lmac_reg_reader: turns AXI4-Lite reads into MAC register-port requests and returns the data.
// Define LMAC_REGRD_TIMEOUT_EN to add the WAIT timeout counter.
module lmac_reg_reader #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 rst,
  lmac_reg_reader_if.slave     axil,
  output logic [15:0]          host_addr_reg,
  output logic                 reg_rd_start,
  input  logic                 reg_rd_done_out,
  input  logic [31:0]          FMAC_REGDOUT,
  output logic                 busy,
  output logic [7:0]           err_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t      r_state, w_next;
  logic        w_mis, w_done, w_tmo, w_to_resp, w_err, w_issue;
  logic [15:0] r_addr;
  logic        r_start, r_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic [7:0]  r_err;
  assign w_mis     = r_state == IDLE && axil.s_axil_arvalid && axil.s_axil_araddr[1:0] != 2'b00;
  assign w_issue   = r_state == IDLE && axil.s_axil_arvalid && axil.s_axil_araddr[1:0] == 2'b00;
  assign w_done    = r_state == WAIT && reg_rd_done_out;
  assign w_to_resp = w_mis || w_done || w_tmo;
  assign w_err     = w_mis || w_tmo;
`ifdef LMAC_REGRD_TIMEOUT_EN
  logic [15:0] r_cnt;
  // counter holds the number of WAIT cycles already spent, so expiry fires in the last one
  assign w_tmo = r_state == WAIT && !reg_rd_done_out && r_cnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    r_cnt <= (rst || r_state == ISSUE) ? '0 : (r_state == WAIT ? r_cnt + 16'd1 : r_cnt);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYCLES == 0;
  assign w_tmo = 1'b0;
`endif
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !axil.s_axil_arvalid ? IDLE : (w_mis ? RESP : ISSUE);
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = (w_done || w_tmo) ? RESP : WAIT;
      RESP:    w_next = axil.s_axil_rready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    axil.s_axil_arready = r_state == IDLE && !rst;
    busy                = r_state != IDLE && !rst;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_start  <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= '0;
      r_err    <= '0;
    end else begin
      r_start <= w_issue;
      if (w_issue) r_addr <= axil.s_axil_araddr[17:2];
      if (w_to_resp) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_err ? ERR_DATA : FMAC_REGDOUT;
        r_rresp  <= w_err ? 2'b10 : 2'b00;
        if (w_err && r_err != 8'hFF) r_err <= r_err + 8'd1;
      end else if (r_state == RESP && axil.s_axil_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end
  assign host_addr_reg      = r_addr;
  assign reg_rd_start       = r_start;
  assign axil.s_axil_rvalid = r_rvalid;
  assign axil.s_axil_rdata  = r_rdata;
  assign axil.s_axil_rresp  = r_rresp;
  assign err_count          = r_err;
endmodule

// File: doc/lmac_reg_reader.md
# lmac_reg_reader

Register-read initiator for the LMAC host register port. Accepts AXI4-Lite read transactions from the host interconnect, converts each into one `host_addr_reg`/`reg_rd_start` request toward the MAC, captures `FMAC_REGDOUT` when `reg_rd_done_out` pulses, and returns the data on the AXI R channel. It sits between the cosim host bridge and the MAC wrapper's register read port. It is the requesting end of the port the MAC answers.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 255: number of WAIT cycles without `reg_rd_done_out` before an error response; legal range 1..65535.
- `ERR_DATA`, default 32'hDEADBEEF: `rdata` value returned with SLVERR.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `s_axil_araddr`  in  18: byte address.
- `s_axil_arvalid`  in  1: read address valid.
- `s_axil_arready`  out  1: read address ready.
- `s_axil_rdata`  out  32: read data.
- `s_axil_rresp`  out  2: 2'b00 OKAY, 2'b10 SLVERR.
- `s_axil_rvalid`  out  1: read data valid.
- `s_axil_rready`  in  1: read data ready.
- `host_addr_reg`  out  16: word address to MAC (`araddr[17:2]`).
- `reg_rd_start`  out  1: one-cycle request pulse to MAC.
- `reg_rd_done_out`  in  1: MAC completion pulse; `FMAC_REGDOUT` is valid in the same cycle.
- `FMAC_REGDOUT`  in  32: MAC read data.
- `busy`  out  1: high in any state other than IDLE.
- `err_count`  out  8: saturating count of SLVERR responses.

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** `s_axil_arready`=1. When `arvalid` is high:
  - `araddr[1:0]`==0: latch `araddr[17:2]` into `host_addr_reg` and go to ISSUE.
  - `araddr[1:0]`!=0 (misaligned): do not start a MAC request. Go to RESP with SLVERR and `ERR_DATA`.
- **ISSUE:** one cycle.
  - `reg_rd_start`=1.
  - Clear the timeout counter, then go to WAIT.
  - `reg_rd_done_out` is ignored in this cycle.
- **WAIT:** the timeout counter increments each cycle.
  - `reg_rd_done_out`=1: register `FMAC_REGDOUT` into `rdata` with OKAY, then go to RESP.
  - Counter reaches `TIMEOUT_CYCLES` with no done: `rdata`=`ERR_DATA`, SLVERR, go to RESP.
  - Done and expiry in the same cycle: done wins, OKAY.
- **RESP:** `s_axil_rvalid`=1.
  - `rdata`/`rresp` are held stable until `rready` is high.
  - On handshake, go to IDLE.
- `host_addr_reg` holds its last value outside active transactions. It is stable from ISSUE through RESP.
- A `reg_rd_done_out` outside WAIT (including a late done after a timeout) is ignored. It never alters `rdata` or state.
- `err_count` increments on entry to RESP with SLVERR and saturates at 255.
- Only one outstanding transaction at a time; no pipelining.

## Timing

- Reset values while `rst` is high:
  - `s_axil_arready`=0, `s_axil_rvalid`=0, `s_axil_rdata`=0, `s_axil_rresp`=0.
  - `reg_rd_start`=0, `host_addr_reg`=0, `busy`=0, `err_count`=0.
  - State is IDLE. `arready`=1 from the first cycle after `rst` falls.
- Reset mid-operation: on the next edge, return to IDLE and drop `rvalid`/`reg_rd_start`. No response is issued for the aborted read.
- AR handshake at cycle N: `reg_rd_start` is high at N+1 only.
- Done at cycle M: `rvalid` is high at M+1.
- Best case, AR handshake to `rvalid`: 3 cycles (done at N+2).
- Timeout: done absent for `TIMEOUT_CYCLES` WAIT cycles gives `rvalid` at ISSUE+`TIMEOUT_CYCLES`+1.
- R handshake at cycle K: `arready` is high at K+1. The earliest next `reg_rd_start` is at K+2.
- `arready` is low in ISSUE, WAIT and RESP.
- All outputs are registered except `s_axil_arready` and `busy`, which are decoded directly from state.

## Configuration

- `LMAC_REGRD_TIMEOUT_EN`
  - Defined: timeout counter present; behaviour as above.
  - Undefined: no counter. WAIT exits only on `reg_rd_done_out`, and `TIMEOUT_CYCLES` is unused. Misaligned SLVERR and `err_count` remain.

## Test plan

- **Aligned read:** `araddr`=18'h00010, MAC done 2 cycles after start with `FMAC_REGDOUT`=32'h12345678.
  - `host_addr_reg`=16'h0004 and a single `reg_rd_start` pulse.
  - `rdata`=32'h12345678, `rresp`=OKAY.
- **Misaligned read:** `araddr`=18'h00012.
  - No `reg_rd_start`.
  - `rdata`=32'hDEADBEEF, `rresp`=SLVERR, `err_count`=1.
- **Timeout** (macro defined, `TIMEOUT_CYCLES`=8): MAC never responds.
  - `rvalid` 9 cycles after ISSUE with SLVERR/32'hDEADBEEF.
  - A done injected 3 cycles later is ignored; the next read returns the correct data.
- **Simultaneous done and expiry:** done arrives in the 8th WAIT cycle.
  - OKAY with the MAC data; `err_count` unchanged.
- **Backpressure:** `rready` held low 5 cycles, while `FMAC_REGDOUT` changes and a stray done is pulsed.
  - `rdata`/`rresp` stable; `arready`=0 throughout; `arready`=1 the cycle after the handshake.
- **Reset in WAIT:** `rst` pulsed 1 cycle.
  - All outputs at reset values, no `rvalid`.
  - A following read at 18'h00100 completes normally with `host_addr_reg`=16'h0040.
